// File: rtl/uart_rx_fifo.sv
// Generic single-clock FIFO: write-through-when-full is allowed only if the same cycle also pops.
// Head entry is visible combinationally (first-word-fall-through); level updates one edge after push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign level_o    = level_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// UART receiver (majority-voted oversampling, optional parity, 1-2 stop bits) feeding a FWFT FIFO.
// Frame is pushed one cycle after the last stop-bit decision; a push into a full FIFO with no same-cycle read is dropped and sets OERR.
module uart_rx_fifo #(
  parameter int CLKFREQ    = 27_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rxd_i,
  input  logic                        rd_i,
  input  logic                        clear_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        perr_o,
  output logic                        ferr_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        oerr_o,
  output logic                        brk_o
);
  localparam int TICK_DIV   = CLKFREQ / (BAUDRATE * OVERSAMPLE);
  localparam int TICK_DIV_C = (TICK_DIV < 1) ? 1 : TICK_DIV;
  localparam int DIV_W      = $clog2(TICK_DIV_C + 1);
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);
  localparam int ENT_W      = DATA_BITS + 2;
  localparam logic [OS_W-1:0] SAMP0 = OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [OS_W-1:0] SAMP1 = OS_W'(OVERSAMPLE/2);
  localparam logic [OS_W-1:0] SAMP2 = OS_W'(OVERSAMPLE/2 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_meta_q, rxd_sync_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      tcnt_q, tcnt_d;
  logic [1:0]           samp_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bit_q, perr_q, ferr_q, brk_frame_q;
  logic                 push_q, push_d;
  logic                 oerr_q, brk_q;
  logic                 tick, decide, maj, start_det, last_stop;
  logic                 shift_en, par_en, stop_en;
  logic [ENT_W-1:0]     head_dat;
  logic                 fifo_empty, fifo_full;

  assign tick      = (div_q == DIV_W'(TICK_DIV_C - 1));
  assign decide    = tick && (tcnt_q == SAMP2);
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);
  assign start_det = (state_q == S_IDLE) && !rxd_sync_q;
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rxd_sync_q) state_d = S_START;
      S_START:   if (decide) state_d = maj ? S_IDLE : S_DATA;
      S_DATA:    if (decide && bit_cnt_q == BIT_W'(DATA_BITS - 1))
                   state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY:  if (decide) state_d = S_STOP;
      S_STOP:    if (decide && last_stop) state_d = maj ? S_IDLE : S_BRKWAIT;
      S_BRKWAIT: if (rxd_sync_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    push_d   = 1'b0;
    case (state_q)
      S_DATA:   shift_en = decide;
      S_PARITY: par_en   = decide;
      S_STOP: begin
        stop_en = decide;
        push_d  = decide && last_stop;
      end
      default: ;
    endcase
  end

  // Tick phase runs continuously across bits, so each state moves on at its mid-bit decision.
  always_comb begin
    div_d  = div_q;
    tcnt_d = tcnt_q;
    if (start_det) begin
      div_d  = '0;
      tcnt_d = '0;
    end else if (tick) begin
      div_d  = '0;
      tcnt_d = (tcnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : tcnt_q + OS_W'(1);
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      div_q       <= '0;
      tcnt_q      <= '0;
      samp_q      <= 2'b11;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_frame_q <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      div_q      <= div_d;
      tcnt_q     <= tcnt_d;
      push_q     <= push_d;
      if (tick && tcnt_q == SAMP0) samp_q[0] <= rxd_sync_q;
      if (tick && tcnt_q == SAMP1) samp_q[1] <= rxd_sync_q;
      if (start_det) begin
        bit_cnt_q   <= '0;
        stop_cnt_q  <= 1'b0;
        par_bit_q   <= 1'b0;
        perr_q      <= 1'b0;
        ferr_q      <= 1'b0;
        brk_frame_q <= 1'b0;
      end
      if (shift_en) begin
        shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
      if (par_en) begin
        par_bit_q <= maj;
        perr_q    <= ((^shreg_q) ^ maj) != 1'(PARITY_ODD);
      end
      if (stop_en) begin
        stop_cnt_q <= stop_cnt_q + 1'b1;
        if (!maj) ferr_q <= 1'b1;
        if (stop_cnt_q == 1'b0) brk_frame_q <= (shreg_q == '0) && !par_bit_q && !maj;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oerr_q <= 1'b0;
      brk_q  <= 1'b0;
    end else if (clear_i) begin
      oerr_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      if (push_q && fifo_full && !rd_i) oerr_q <= 1'b1;
      if (push_q && brk_frame_q)        brk_q  <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_q),
    .push_dat_i ({perr_q, ferr_q, shreg_q}),
    .pop_i      (rd_i),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .level_o    (level_o)
  );

  assign empty_o = fifo_empty;
  assign full_o  = fifo_full;
  assign data_o  = fifo_empty ? '0 : head_dat[DATA_BITS-1:0];
  assign ferr_o  = fifo_empty ? 1'b0 : head_dat[DATA_BITS];
  assign perr_o  = fifo_empty ? 1'b0 : head_dat[DATA_BITS+1];
  assign oerr_o  = oerr_q;
  assign brk_o   = brk_q;
endmodule
